ex_fsm: RTL and testbench
=========================

Name: ex_fsm

Overview:
- Four-state Moore-style sequence controller driven by a single serial control input A.
- Detects the pattern rise → fall → rise → fall on A.
- Asserts k2 while the second high phase is in progress, and k1 once the full sequence has completed.
- Small control leaf used as a sequence/handshake detector inside larger control logic.

Parameters:
- SYNC_STAGES, 2, number of flops in the optional input synchronizer (legal values 2..3). Ignored when EX_FSM_SYNC_EN is undefined.

Ports:
- sclk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- A  input  1  control input, sampled on the sclk rising edge.
- k1  output  1  registered; set when the sequence completes, cleared on restart.
- k2  output  1  registered; high while the FSM is in CLEAR.

Behaviour:
- Reset: one clock, synchronous, active-low. While rst_n=0 at a sclk rising edge:
  - state <= IDLE, k1 <= 0, k2 <= 0.
  - Reset applied mid-sequence aborts it and behaves identically.
- States, one-hot encoded: IDLE=4'b0001, START=4'b0010, STOP=4'b0100, CLEAR=4'b1000.
- Transitions, evaluated each rising edge with rst_n=1, using A as sampled that edge:
  - IDLE: A=1 → START, k1 <= 0. A=0 → stay, outputs hold.
  - START: A=0 → STOP, outputs hold. A=1 → stay.
  - STOP: A=1 → CLEAR, k2 <= 1. A=0 → stay.
  - CLEAR: A=0 → IDLE, k1 <= 1, k2 <= 0. A=1 → stay.
- Outputs are registered and hold their value unless a transition above changes them.
- Latency: an output change is visible one sclk cycle after the edge that sampled the triggering A level.
- k1 stays high from sequence completion until the next IDLE→START transition; it is a level, not a pulse.
- Illegal or non-one-hot state value (including X after power-up without reset): next edge forces IDLE, k1 <= 0, k2 <= 0.
- A unknown (X/Z) while in any state: treat as "no transition"; the state holds. Implement with explicit ===1 / ===0 comparisons in simulation-safe code, or equivalent default-hold logic.
- Every state stays put while A keeps its current level. There is no timeout, so a long A level dwells indefinitely.
- Single-cycle A glitches are honoured: each level change advances at most one state per edge.

Optional Feature:
- Macro EX_FSM_SYNC_EN.
- Defined:
  - A passes through a SYNC_STAGES-deep flop chain clocked by sclk.
  - The chain is reset to 0 by rst_n.
  - The FSM uses the chain output, so total latency A→output becomes SYNC_STAGES+1 cycles.
- Undefined: A feeds the FSM directly, with 1-cycle latency; SYNC_STAGES is unused.

Decomposition:
- Package ex_fsm_pkg holds:
  - the state localparams/typedef (IDLE, START, STOP, CLEAR one-hot values);
  - the state width constant (4).
- Optional sub-module ex_fsm_sync: the parameterised synchronizer chain, instantiated only under EX_FSM_SYNC_EN.
- The FSM core remains in ex_fsm.

Test Plan:
- Reset hold: rst_n=0 for 5 cycles with A=1 → state IDLE, k1=0, k2=0 throughout.
- Full sequence (20 ns clock, reset released at 100 ns, stimulus from cycle 0 at 200 ns). A=0 cycles 0–49, 1 cycles 50–199, 0 cycles 200–699, 1 cycles 700–799, 0 from cycle 800:
  - START one cycle after A rises at 50.
  - STOP after 200.
  - CLEAR with k2=1 after 700.
  - IDLE with k1=1, k2=0 after 800.
  - k1 stays 1 to the end.
- Restart: after the completed sequence, A=1 → IDLE→START and k1 drops to 0 one cycle later.
- Mid-sequence reset: reach CLEAR (k2=1), then rst_n=0 for 1 cycle → next edge IDLE, k1=0, k2=0.
- Dwell/glitch: in STOP apply A=1 for one cycle then 0 → CLEAR then IDLE on consecutive edges, k2 high for exactly 1 cycle, then k1=1.
- With EX_FSM_SYNC_EN, SYNC_STAGES=2: repeat the full sequence → every output edge delayed by exactly 2 extra cycles versus the non-sync build.

Source files
------------

// File: rtl/ex_fsm_pkg.sv
// Shared definitions for the ex_fsm sequence controller.
// Holds the one-hot state encoding and its width.
// No logic lives here; ex_fsm and ex_fsm_sync import it.
package ex_fsm_pkg;

  localparam int STATE_W = 4;

  // One-hot encoding. Any other value is treated as illegal and recovers to IDLE.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    STOP  = 4'b0100,
    CLEAR = 4'b1000
  } state_t;

endpackage

// File: rtl/ex_fsm_sync.sv
// Purpose: STAGES-deep flop chain that brings the control input into the sclk domain.
// Latency: STAGES sclk cycles from din to dout.
// Backpressure: none; a free-running shift chain.
// Ports: sclk (clock), rst_n (sync active-low, clears the chain to 0), din (raw input), dout (synchronized).
module ex_fsm_sync #(
  parameter int STAGES = 2
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  import ex_fsm_pkg::*;

  logic [STAGES-1:0] chain;

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
    end
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/ex_fsm.sv
// Purpose: Moore sequence controller detecting rise->fall->rise->fall on A.
// Latency: outputs change 1 sclk after the triggering A sample (SYNC_STAGES+1 with EX_FSM_SYNC_EN).
// Backpressure: none; A is sampled every rising edge.
// Ports: sclk (clock), rst_n (sync active-low reset), A (control input),
//        k1 (level, set on sequence completion, cleared on restart), k2 (high while in CLEAR).
// Build option: define EX_FSM_SYNC_EN to route A through a SYNC_STAGES-deep synchronizer.
module ex_fsm #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic A,
  output logic k1,
  output logic k2
);
  import ex_fsm_pkg::*;

  logic   a_s;
  state_t state;
  state_t state_nxt;
  logic   k1_nxt;
  logic   k2_nxt;

`ifdef EX_FSM_SYNC_EN
  ex_fsm_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .sclk  (sclk),
    .rst_n (rst_n),
    .din   (A),
    .dout  (a_s)
  );
`else
  // SYNC_STAGES has no role without the synchronizer; keep it referenced.
  logic [31:0] unused_sync_stages;
  assign unused_sync_stages = SYNC_STAGES;
  assign a_s = A;
`endif

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state <= IDLE;
      k1    <= 1'b0;
      k2    <= 1'b0;
    end else begin
      state <= state_nxt;
      k1    <= k1_nxt;
      k2    <= k2_nxt;
    end
  end

  // Explicit ===1 / ===0 tests: an unknown A matches neither, so the state
  // and outputs hold. Unknown or non-one-hot state falls into default.
  always_comb begin
    state_nxt = state;
    k1_nxt    = k1;
    k2_nxt    = k2;
    case (state)
      IDLE: begin
        if (a_s === 1'b1) begin
          state_nxt = START;
          k1_nxt    = 1'b0;
        end
      end
      START: begin
        if (a_s === 1'b0) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (a_s === 1'b1) begin
          state_nxt = CLEAR;
          k2_nxt    = 1'b1;
        end
      end
      CLEAR: begin
        if (a_s === 1'b0) begin
          state_nxt = IDLE;
          k1_nxt    = 1'b1;
          k2_nxt    = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        k1_nxt    = 1'b0;
        k2_nxt    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ex_fsm.sv
// Directed self-checking bench for ex_fsm.
// Expected values are hand-derived from the sequence rules; L is the extra
// synchronizer latency (2 when EX_FSM_SYNC_EN is defined, else 0).
`timescale 1ns/1ps
module tb_ex_fsm;
  import ex_fsm_pkg::*;

`ifdef EX_FSM_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic tb_sclk = 1'b0;
  logic rst_n   = 1'b0;
  logic a       = 1'b0;
  logic k1;
  logic k2;

  int checks   = 0;
  int failures = 0;

  always #10 tb_sclk = ~tb_sclk;

  ex_fsm #(
    .SYNC_STAGES (2)
  ) dut (
    .sclk  (tb_sclk),
    .rst_n (rst_n),
    .A     (a),
    .k1    (k1),
    .k2    (k2)
  );

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge tb_sclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({dut.state, k1, k2} !== {IDLE, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_hold[%0d] got state=%b k1=%b k2=%b want state=%b k1=0 k2=0",
                 i, dut.state, k1, k2, IDLE);
      end
    end
    a     = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_full_sequence();
    int k2_high = 0;
    int k2_rise = -1;
    int k1_rise = -1;
    for (int c = 0; c < 900; c++) begin
      a = ((c >= 50 && c < 200) || (c >= 700 && c < 800)) ? 1'b1 : 1'b0;
      tick();
      if (c == 49 + L || c == 50 + L || c == 199 + L || c == 200 + L ||
          c == 699 + L || c == 700 + L || c == 799 + L || c == 800 + L) begin
        logic [STATE_W+1:0] want;
        if (c < 50 + L)       want = {IDLE,  1'b0, 1'b0};
        else if (c < 200 + L) want = {START, 1'b0, 1'b0};
        else if (c < 700 + L) want = {STOP,  1'b0, 1'b0};
        else if (c < 800 + L) want = {CLEAR, 1'b0, 1'b1};
        else                  want = {IDLE,  1'b1, 1'b0};
        checks++;
        if ({dut.state, k1, k2} !== want) begin
          failures++;
          $display("FAIL full_seq cycle %0d got {state,k1,k2}=%b want %b",
                   c, {dut.state, k1, k2}, want);
        end
      end
      if (k2 === 1'b1) begin
        k2_high++;
        if (k2_rise < 0) k2_rise = c;
      end
      if (k1 === 1'b1 && k1_rise < 0) k1_rise = c;
    end
    checks++;
    if (k2_high != 100) begin
      failures++;
      $display("FAIL full_seq_k2_width got %0d cycles want 100", k2_high);
    end
    checks++;
    if (k2_rise != 700 + L) begin
      failures++;
      $display("FAIL full_seq_k2_rise got cycle %0d want %0d", k2_rise, 700 + L);
    end
    checks++;
    if (k1_rise != 800 + L) begin
      failures++;
      $display("FAIL full_seq_k1_rise got cycle %0d want %0d", k1_rise, 800 + L);
    end
    checks++;
    if (k1 !== 1'b1) begin
      failures++;
      $display("FAIL full_seq_k1_hold got %b want 1", k1);
    end
  endtask

  task automatic test_restart();
    a = 1'b1;
    for (int i = 0; i <= L; i++) begin
      tick();
      checks++;
      if (i < L) begin
        if ({dut.state, k1, k2} !== {IDLE, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL restart_wait[%0d] got {state,k1,k2}=%b want %b",
                   i, {dut.state, k1, k2}, {IDLE, 1'b1, 1'b0});
        end
      end else begin
        if ({dut.state, k1, k2} !== {START, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL restart got {state,k1,k2}=%b want %b",
                   {dut.state, k1, k2}, {START, 1'b0, 1'b0});
        end
      end
    end
    a = 1'b0;
    for (int i = 0; i <= L; i++) tick();
  endtask

  task automatic test_mid_reset();
    // Starts in STOP; go to CLEAR, then abort with a one-cycle reset.
    a = 1'b1;
    for (int i = 0; i <= L; i++) tick();
    checks++;
    if ({dut.state, k1, k2} !== {CLEAR, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL mid_reset_reach_clear got {state,k1,k2}=%b want %b",
               {dut.state, k1, k2}, {CLEAR, 1'b0, 1'b1});
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({dut.state, k1, k2} !== {IDLE, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset got {state,k1,k2}=%b want %b",
               {dut.state, k1, k2}, {IDLE, 1'b0, 1'b0});
    end
    rst_n = 1'b1;
    a     = 1'b0;
    for (int i = 0; i < L + 2; i++) tick();
    checks++;
    if ({dut.state, k1, k2} !== {IDLE, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset_after got {state,k1,k2}=%b want %b",
               {dut.state, k1, k2}, {IDLE, 1'b0, 1'b0});
    end
  endtask

  task automatic test_glitch();
    int k2_cnt = 0;
    a = 1'b1;
    for (int i = 0; i <= L; i++) tick();
    a = 1'b0;
    for (int i = 0; i <= L; i++) tick();
    checks++;
    if ({dut.state, k1, k2} !== {STOP, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL glitch_reach_stop got {state,k1,k2}=%b want %b",
               {dut.state, k1, k2}, {STOP, 1'b0, 1'b0});
    end
    // Single-cycle A pulse sampled at edge 0.
    for (int e = 0; e < 7; e++) begin
      a = (e == 0) ? 1'b1 : 1'b0;
      tick();
      if (k2 === 1'b1) k2_cnt++;
      if (e == L) begin
        checks++;
        if ({dut.state, k1, k2} !== {CLEAR, 1'b0, 1'b1}) begin
          failures++;
          $display("FAIL glitch_clear got {state,k1,k2}=%b want %b",
                   {dut.state, k1, k2}, {CLEAR, 1'b0, 1'b1});
        end
      end
      if (e == L + 1) begin
        checks++;
        if ({dut.state, k1, k2} !== {IDLE, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL glitch_idle got {state,k1,k2}=%b want %b",
                   {dut.state, k1, k2}, {IDLE, 1'b1, 1'b0});
        end
      end
    end
    checks++;
    if (k2_cnt != 1) begin
      failures++;
      $display("FAIL glitch_k2_width got %0d cycles want 1", k2_cnt);
    end
    checks++;
    if (k1 !== 1'b1) begin
      failures++;
      $display("FAIL glitch_k1_end got %b want 1", k1);
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_restart();
    test_mid_reset();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
